// File: rtl/multiplier_operator_if.sv
// Operand/result bundle between the bus wrapper (master) and the multiplier (slave).
interface multiplier_operator_if;
  logic         op_start;
  logic         op_clear;
  logic [63:0]  multiplicand;
  logic [63:0]  multiplier;
  logic [127:0] result;
  logic [1:0]   state;

  modport master (
    output op_start, op_clear, multiplicand, multiplier,
    input  result, state
  );

  modport slave (
    input  op_start, op_clear, multiplicand, multiplier,
    output result, state
  );
endinterface

// File: rtl/multiplier_operator.sv
// Sequential 64x64 signed multiplier, radix-4 Booth, one triplet per clock (32 cycles).
module multiplier_operator (
  input  logic                 clk,
  input  logic                 reset_n,
  multiplier_operator_if.slave bus
);

  // state | meaning
  // IDLE  | waiting for op_start, result = 0
  // EXEC  | 32 Booth iterations in progress, result = 0
  // DONE  | product on result, held until op_clear
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t       state_q;
  state_t       state_d;
  logic [63:0]  a_reg;
  logic [65:0]  upper;
  logic [63:0]  lower;
  logic         b_m1;
  logic [4:0]   cnt;

  logic [65:0]  a_ext;
  logic [65:0]  a_x2;
  logic [65:0]  addend;
  logic [65:0]  sum;
  logic [65:0]  upper_nxt;
  logic [63:0]  lower_nxt;

  assign a_ext = {{2{a_reg[63]}}, a_reg};
  assign a_x2  = {a_reg[63], a_reg, 1'b0};

  always_comb begin
    addend = '0;
    case ({lower[1], lower[0], b_m1})
      3'b001, 3'b010: addend = a_ext;
      3'b011:         addend = a_x2;
      3'b100:         addend = -a_x2;
      3'b101, 3'b110: addend = -a_ext;
      default:        addend = '0;
    endcase
  end

  // Add into the upper half, then arithmetic-shift {upper, lower, b_m1} right by 2.
  assign sum       = upper + addend;
  assign upper_nxt = {{2{sum[65]}}, sum[65:2]};
  assign lower_nxt = {sum[1:0], lower[63:2]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.op_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.op_start) state_d = EXEC;
        EXEC:    if (cnt == 5'd31) state_d = DONE;
        DONE:    state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_reg      <= '0;
      upper      <= '0;
      lower      <= '0;
      b_m1       <= 1'b0;
      cnt        <= '0;
      bus.result <= '0;
    end else if (bus.op_clear) begin
      cnt        <= '0;
      bus.result <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.op_start) begin
            a_reg      <= bus.multiplicand;
            lower      <= bus.multiplier;
            upper      <= '0;
            b_m1       <= 1'b0;
            cnt        <= '0;
            bus.result <= '0;
          end
        end
        EXEC: begin
          upper <= upper_nxt;
          lower <= lower_nxt;
          b_m1  <= lower[1];
          cnt   <= cnt + 5'd1;
          // The full 130-bit register holds the exact product; its low 128 bits suffice.
          if (cnt == 5'd31) bus.result <= {sum[65:2], lower_nxt};
        end
        default: ;
      endcase
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_multiplier_operator.sv
// Randomized scoreboard bench for multiplier_operator.
module tb_multiplier_operator;

  logic clk;
  logic reset_n;
  multiplier_operator_if bus ();

  multiplier_operator dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [127:0] sb[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] sa, sbv;
    sa  = $signed({{64{a[63]}}, a});
    sbv = $signed({{64{b[63]}}, b});
    return sa * sbv;
  endfunction

  // Monitor: pops one expected product per entry into DONE; checks result=0 in EXEC and stability in DONE.
  logic [1:0]   prev_state = 2'b00;
  logic [127:0] prev_result = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.state == 2'b01) check("result_zero_in_exec", bus.result, 128'd0);
      if (bus.state == 2'b10 && prev_state != 2'b10) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {126'd0, bus.state}, 128'd0);
        end else begin
          check("product", bus.result, sb.pop_front());
        end
      end else if (bus.state == 2'b10) begin
        check("done_stable", bus.result, prev_result);
      end
    end
    prev_state  = reset_n ? bus.state : 2'b00;
    prev_result = bus.result;
  end

  // Starts an op (start held one cycle), scrambles inputs during EXEC, times completion, clears.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input string tag);
    int n;
    @(negedge clk);
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.op_start     = 1'b1;
    sb.push_back(ref_mul(a, b));
    @(negedge clk);
    check({tag, "_state_exec"}, {126'd0, bus.state}, 128'd1);
    bus.op_start     = 1'b0;
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier   = {$urandom, $urandom};
    n = 1;
    while (bus.state == 2'b01 && n < 40) begin
      @(negedge clk);
      if (bus.state == 2'b01) n++;
      if (n == 5) bus.op_start = 1'b1;
    end
    bus.op_start = 1'b0;
    check({tag, "_exec_cycles"}, n, 32);
    check({tag, "_state_done"}, {126'd0, bus.state}, 128'd2);
    @(negedge clk);
    check({tag, "_hold_done"}, {126'd0, bus.state}, 128'd2);
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;
    check({tag, "_clear_state"}, {126'd0, bus.state}, 128'd0);
    check({tag, "_clear_result"}, bus.result, 128'd0);
  endtask

  initial begin
    int n;
    reset_n          = 1'b0;
    bus.op_start     = 1'b0;
    bus.op_clear     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    #12;
    check("reset_state", {126'd0, bus.state}, 128'd0);
    check("reset_result", bus.result, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {126'd0, bus.state}, 128'd0);

    // Mixed-sign with op_start held high, then clear with start still high.
    bus.multiplicand = 64'd2147483647;
    bus.multiplier   = -64'sd1431655766;
    bus.op_start     = 1'b1;
    sb.push_back(ref_mul(bus.multiplicand, bus.multiplier));
    n = 0;
    repeat (35) begin
      @(negedge clk);
      if (bus.state == 2'b01) n++;
    end
    check("held_exec_cycles", n, 32);
    check("held_state_done", {126'd0, bus.state}, 128'd2);
    check("mixed_sign_const", bus.result, 128'hFFFFFFFFFFFFFFFF_D555555555555556);
    bus.op_clear = 1'b1;
    sb.push_back(ref_mul(bus.multiplicand, bus.multiplier));
    @(negedge clk);
    bus.op_clear = 1'b0;
    check("clear_held_state", {126'd0, bus.state}, 128'd0);
    check("clear_held_result", bus.result, 128'd0);
    @(negedge clk);
    check("restart_after_clear", {126'd0, bus.state}, 128'd1);
    bus.op_start = 1'b0;
    n = 0;
    while (bus.state != 2'b10 && n < 40) begin @(negedge clk); n++; end
    check("restart_done", {126'd0, bus.state}, 128'd2);
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;

    do_op(64'h8000000000000000, 64'h8000000000000000, "min_sq");
    do_op(64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, "m1_sq");
    do_op(64'd0, {$urandom, $urandom}, "zero");
    do_op(64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF, "max_sq");
    do_op(64'h8000000000000000, 64'h7FFFFFFFFFFFFFFF, "min_max");
    for (int i = 0; i < 10; i++) do_op({$urandom, $urandom}, {$urandom, $urandom}, "rand");
    check("max_sq_ref", ref_mul(64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF),
          128'h3FFFFFFFFFFFFFFF_0000000000000001);

    // Abort with op_clear during cycle 10 of EXEC.
    @(negedge clk);
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier   = {$urandom, $urandom};
    bus.op_start     = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_in_exec", {126'd0, bus.state}, 128'd1);
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;
    check("abort_state", {126'd0, bus.state}, 128'd0);
    check("abort_result", bus.result, 128'd0);
    do_op({$urandom, $urandom}, {$urandom, $urandom}, "after_abort");

    // Start and clear together in IDLE.
    @(negedge clk);
    bus.op_start = 1'b1;
    bus.op_clear = 1'b1;
    @(negedge clk);
    check("start_clear_idle", {126'd0, bus.state}, 128'd0);
    bus.op_start = 1'b0;
    bus.op_clear = 1'b0;

    // Asynchronous reset mid-EXEC.
    @(negedge clk);
    bus.multiplicand = {$urandom, $urandom};
    bus.multiplier   = {$urandom, $urandom};
    bus.op_start     = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    repeat (6) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_state", {126'd0, bus.state}, 128'd0);
    check("async_reset_result", bus.result, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op({$urandom, $urandom}, {$urandom, $urandom}, "after_reset");

    repeat (2) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
